// File: rtl/risc_v_32_if.sv
// RV32I instruction-fetch stage: PC register, single-outstanding imem handshake, small FIFO feeding decode.
// Optional macro IF_MISALIGN_TRAP_EN: a misaligned redirect halts fetching and raises fetch_misalign_o.
module risc_v_32_if #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        fetch_misalign_o
);
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic          outstanding;
    logic          discard;
    logic          stop;
    logic [31:0]   fifo_pc   [BUF_DEPTH];
    logic [31:0]   fifo_inst [BUF_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW+1:0] occupancy;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          fire;
    logic          space;
    logic [31:0]   target_pc;
    logic          target_misaligned;

`ifdef IF_MISALIGN_TRAP_EN
    assign target_pc         = redirect_pc_i;
    assign target_misaligned = (redirect_pc_i[1:0] != 2'b00);
`else
    logic unused_pc_lsbs;
    assign unused_pc_lsbs    = ^redirect_pc_i[1:0];
    assign target_pc         = {redirect_pc_i[31:2], 2'b00};
    assign target_misaligned = 1'b0;
`endif

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(BUF_DEPTH));
    assign valid_o = ~empty & ~redirect_i;
    assign pop     = valid_o & ready_i;
    assign inst_o  = fifo_inst[rd_ptr];
    assign pc_o    = fifo_pc[rd_ptr];

    // An in-flight response already owns a FIFO slot, so count it before issuing another fetch.
    assign occupancy = {1'b0, count} - {{(AW+1){1'b0}}, pop} + {{(AW+1){1'b0}}, outstanding};
    assign space     = (occupancy < (AW+2)'(BUF_DEPTH));

    assign imem_req  = rst_n & ~redirect_i & ~stop & ~discard & (~outstanding | imem_rvalid) & space;
    assign imem_addr = pc;
    assign fire      = imem_req & imem_gnt;
    assign push      = imem_rvalid & outstanding & ~discard & ~redirect_i;

    assign fetch_misalign_o = stop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            req_pc      <= RESET_PC;
            outstanding <= 1'b0;
            discard     <= (outstanding | discard) & ~imem_rvalid;
            stop        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_i) begin
            pc          <= target_pc;
            outstanding <= outstanding & ~imem_rvalid;
            discard     <= (outstanding | discard) & ~imem_rvalid;
            stop        <= target_misaligned;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (fire) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
            end
            if (fire) begin
                outstanding <= 1'b1;
            end else if (imem_rvalid) begin
                outstanding <= 1'b0;
            end
            if (imem_rvalid) begin
                discard <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= req_pc;
            fifo_inst[wr_ptr] <= imem_rdata;
        end
    end

    // The space check makes an overflowing push impossible; flag it if it ever happens.
    always_ff @(posedge clk) begin
        if (rst_n && !redirect_i) begin
            assert (!(push && full && !pop));
        end
    end
endmodule
